// File: rtl/tbuf_arb_pkg.sv
// Shared types and limits for the tristate bus arbiter.
// The state encoding is fixed at 2 bits so it can be probed on a debug bus.
package tbuf_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRIVE = 2'd2,
      TURN  = 2'd3
   } arb_state_t;

   localparam int N_REQ_MIN    = 2;
   localparam int N_REQ_MAX    = 8;
   localparam int TURN_CYC_MIN = 1;
   localparam int TURN_CYC_MAX = 7;
   localparam int MAX_HOLD_MIN = 2;
   localparam int MAX_HOLD_MAX = 255;

   localparam int TURN_W = $clog2(TURN_CYC_MAX + 1);
   localparam int HOLD_W = $clog2(MAX_HOLD_MAX + 1);

   function automatic int owner_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tbuf_bus_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req bit at or above start, with wrap.
import tbuf_arb_pkg::*;

module rr_pick #(
   parameter int N_REQ = 4,
   parameter int W     = owner_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [W-1:0]     start,
   output logic             found,
   output logic [W-1:0]     idx
);

   logic [W-1:0] cand [N_REQ];

   // cand[k] is the requester index k positions after start, modulo N_REQ
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [W:0] sum;
      assign sum       = {1'b0, start} + (W+1)'(gi);
      assign cand[gi]  = (sum >= (W+1)'(N_REQ)) ? W'(sum - (W+1)'(N_REQ)) : sum[W-1:0];
   end

   // Scan farthest offset first so the nearest set bit is the final assignment
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[cand[i]]) begin
            found = 1'b1;
            idx   = cand[i];
         end
      end
   end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner sequencer for a shared bus of inverting tristate drivers.
// Every handover goes through enable-low TURN cycles and a SETUP cycle.
import tbuf_arb_pkg::*;

module tbuf_bus_arbiter #(
   parameter int N_REQ    = 4,
   parameter int TURN_CYC = 1,
   parameter int MAX_HOLD = 16,
   localparam int OW      = owner_w(N_REQ)
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [N_REQ-1:0] en,
   output logic [OW-1:0]    owner,
   output logic             bus_idle,
   output logic             preempt
);

   localparam int TURN_EFF = (TURN_CYC < TURN_CYC_MIN) ? TURN_CYC_MIN :
                             (TURN_CYC > TURN_CYC_MAX) ? TURN_CYC_MAX : TURN_CYC;
   localparam int HOLD_EFF = (MAX_HOLD < MAX_HOLD_MIN) ? MAX_HOLD_MIN :
                             (MAX_HOLD > MAX_HOLD_MAX) ? MAX_HOLD_MAX : MAX_HOLD;

   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_EFF - 1);
   localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(HOLD_EFF);
   localparam logic [N_REQ-1:0]  ONE       = N_REQ'(1);

   arb_state_t        state_reg;
   logic [OW-1:0]     rr_ptr_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [TURN_W-1:0] turn_cnt_reg;

   logic              pick_found;
   logic [OW-1:0]     pick_idx;
   logic              owner_req;
   logic              others_pending;
   logic              force_off;
   logic [OW-1:0]     rr_next;

   rr_pick #(
      .N_REQ (N_REQ),
      .W     (OW)
   ) u_rr_pick (
      .req   (req),
      .start (rr_ptr_reg),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign owner_req      = req[owner];
   assign others_pending = |(req & ~gnt);
   assign force_off      = (hold_cnt_reg == HOLD_LIM) && others_pending;
   assign rr_next        = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_reg    <= IDLE;
         gnt          <= '0;
         en           <= '0;
         owner        <= '0;
         bus_idle     <= 1'b1;
         preempt      <= 1'b0;
         rr_ptr_reg   <= '0;
         hold_cnt_reg <= '0;
         turn_cnt_reg <= '0;
      end else begin
         preempt <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pick_found) begin
                  gnt       <= ONE << pick_idx;
                  owner     <= pick_idx;
                  bus_idle  <= 1'b0;
                  state_reg <= SETUP;
               end
            end
            SETUP: begin
               if (owner_req) begin
                  en           <= gnt;
                  hold_cnt_reg <= HOLD_W'(1);
                  state_reg    <= DRIVE;
               end else begin
                  gnt          <= '0;
                  bus_idle     <= 1'b1;
                  rr_ptr_reg   <= rr_next;
                  turn_cnt_reg <= '0;
                  state_reg    <= TURN;
               end
            end
            DRIVE: begin
               if (!owner_req || force_off) begin
                  gnt          <= '0;
                  en           <= '0;
                  bus_idle     <= 1'b1;
                  // only a still-requesting owner counts as preempted
                  preempt      <= owner_req;
                  rr_ptr_reg   <= rr_next;
                  turn_cnt_reg <= '0;
                  state_reg    <= TURN;
               end else if (hold_cnt_reg != HOLD_LIM) begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
            end
            TURN: begin
               if (turn_cnt_reg == TURN_LAST) begin
                  if (pick_found) begin
                     gnt       <= ONE << pick_idx;
                     owner     <= pick_idx;
                     bus_idle  <= 1'b0;
                     state_reg <= SETUP;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else begin
                  turn_cnt_reg <= turn_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
